// File: rtl/bias_glb_ctrl.sv
// Bias global-buffer sequencer: FIFO -> port A load, then port B serve.
// Optional BIAS_GLB_CTRL_ZERO_PAD_EN zeroes unused lanes of a partial last word.
module bias_glb_ctrl #(
   parameter  int FIFO_WIDTH = 64,
   parameter  int DATA_WIDTH = 16,
   parameter  int MEM_DEPTH  = 16,
   parameter  int PASS_WIDTH = 8,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   cfg_num_bias,
   input  logic [PASS_WIDTH-1:0] cfg_num_passes,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  glb_we_a,
   output logic                  glb_re_a,
   output logic [ADDR_WIDTH-1:0] glb_addr_a,
   output logic [FIFO_WIDTH-1:0] glb_wdata_a,
   output logic                  glb_we_b,
   output logic                  glb_re_b,
   output logic [ADDR_WIDTH-1:0] glb_addr_b,
   input  logic [DATA_WIDTH-1:0] glb_rdata_b,
   input  logic                  bias_req,
   output logic                  bias_ready,
   output logic                  bias_valid,
   output logic [DATA_WIDTH-1:0] bias_data,
   output logic [ADDR_WIDTH-1:0] bias_idx,
   output logic                  busy,
   output logic                  load_done,
   output logic                  done
);

   localparam int WC_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SERVE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ADDR_WIDTH:0]   num_bias;
   logic [PASS_WIDTH-1:0] num_passes;
   logic [PASS_WIDTH-1:0] pass_cnt;
   logic [WC_W-1:0]       word_cnt;
   logic [WC_W-1:0]       last_word;
   logic [ADDR_WIDTH-1:0] ch_cnt;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  re_b;
   logic                  valid;
   logic                  fin;
   logic                  ld_done;

   logic                  cfg_ok;
   logic                  wr;
   logic                  wr_last;
   logic                  accept;
   logic                  ch_wrap;
   logic                  pass_last;
   logic [FIFO_WIDTH-1:0] wdata;

   assign cfg_ok = start
                 && (cfg_num_bias != '0)
                 && (cfg_num_bias <= DEPTH_C)
                 && (cfg_num_passes != '0);

   assign wr      = (state == LOAD) && !fifo_empty;
   assign wr_last = wr && (word_cnt == last_word);

   // one read in flight: the issue cycle and the return cycle block new accepts
   assign bias_ready = (state == SERVE) && !re_b && !valid && !fin;
   assign accept     = bias_req && bias_ready;

   assign ch_wrap   = ({1'b0, ch_cnt} == (num_bias - 1'b1));
   assign pass_last = (pass_cnt == (num_passes - 1'b1));

`ifdef BIAS_GLB_CTRL_ZERO_PAD_EN
   always_comb begin
      wdata = fifo_dout;
      if ((word_cnt == last_word) && (num_bias[1:0] != 2'b00)) begin
         for (int l = 0; l < 4; l++) begin
            if (2'(l) >= num_bias[1:0]) begin
               wdata[l*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
         end
      end
   end
`else
   assign wdata = fifo_dout;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cfg_ok) state_nxt = LOAD;
         end
         LOAD: begin
            if (wr_last) state_nxt = SERVE;
         end
         SERVE: begin
            if (valid && fin) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         num_bias   <= '0;
         num_passes <= '0;
         pass_cnt   <= '0;
         word_cnt   <= '0;
         last_word  <= '0;
         ch_cnt     <= '0;
         addr_b     <= '0;
         idx        <= '0;
         re_b       <= 1'b0;
         valid      <= 1'b0;
         fin        <= 1'b0;
         ld_done    <= 1'b0;
      end else begin
         ld_done <= wr_last;
         re_b    <= accept;
         valid   <= re_b;
         if (re_b) idx <= addr_b;
         if ((state == IDLE) && cfg_ok) begin
            num_bias   <= cfg_num_bias;
            num_passes <= cfg_num_passes;
            last_word  <= WC_W'((cfg_num_bias - 1'b1) >> 2);
            word_cnt   <= '0;
            ch_cnt     <= '0;
            pass_cnt   <= '0;
            fin        <= 1'b0;
         end
         if (wr) begin
            word_cnt <= wr_last ? '0 : word_cnt + 1'b1;
         end
         if (accept) begin
            addr_b <= ch_cnt;
            if (ch_wrap) begin
               ch_cnt   <= '0;
               pass_cnt <= pass_cnt + 1'b1;
               if (pass_last) fin <= 1'b1;
            end else begin
               ch_cnt <= ch_cnt + 1'b1;
            end
         end
         if (valid && fin) fin <= 1'b0;
      end
   end

   assign fifo_rd_en  = wr;
   assign glb_we_a    = wr;
   assign glb_re_a    = 1'b0;
   assign glb_addr_a  = ADDR_WIDTH'({word_cnt, 2'b00});
   assign glb_wdata_a = wr ? wdata : '0;
   assign glb_we_b    = 1'b0;
   assign glb_re_b    = re_b;
   assign glb_addr_b  = addr_b;
   assign bias_valid  = valid;
   assign bias_data   = valid ? glb_rdata_b : '0;
   assign bias_idx    = idx;
   assign busy        = (state != IDLE);
   assign load_done   = ld_done;
   assign done        = valid && fin;

endmodule

// File: tb/tb_bias_glb_ctrl.sv
// Randomized bench for bias_glb_ctrl against a sweep-order reference model.
// Holds the buffer memory and a first-word-fall-through FIFO model.
module tb_bias_glb_ctrl;

   localparam int FW = 64;
   localparam int DW = 16;
   localparam int MD = 16;
   localparam int PW = 8;
   localparam int AW = 4;
`ifdef BIAS_GLB_CTRL_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW:0]   cfg_num_bias;
   logic [PW-1:0] cfg_num_passes;
   logic          fifo_empty;
   logic [FW-1:0] fifo_dout;
   logic          fifo_rd_en;
   logic          glb_we_a;
   logic          glb_re_a;
   logic [AW-1:0] glb_addr_a;
   logic [FW-1:0] glb_wdata_a;
   logic          glb_we_b;
   logic          glb_re_b;
   logic [AW-1:0] glb_addr_b;
   logic [DW-1:0] glb_rdata_b;
   logic          bias_req;
   logic          bias_ready;
   logic          bias_valid;
   logic [DW-1:0] bias_data;
   logic [AW-1:0] bias_idx;
   logic          busy;
   logic          load_done;
   logic          done;

   bias_glb_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .cfg_num_bias   (cfg_num_bias),
      .cfg_num_passes (cfg_num_passes),
      .fifo_empty     (fifo_empty),
      .fifo_dout      (fifo_dout),
      .fifo_rd_en     (fifo_rd_en),
      .glb_we_a       (glb_we_a),
      .glb_re_a       (glb_re_a),
      .glb_addr_a     (glb_addr_a),
      .glb_wdata_a    (glb_wdata_a),
      .glb_we_b       (glb_we_b),
      .glb_re_b       (glb_re_b),
      .glb_addr_b     (glb_addr_b),
      .glb_rdata_b    (glb_rdata_b),
      .bias_req       (bias_req),
      .bias_ready     (bias_ready),
      .bias_valid     (bias_valid),
      .bias_data      (bias_data),
      .bias_idx       (bias_idx),
      .busy           (busy),
      .load_done      (load_done),
      .done           (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // stimulus-side state
   logic [FW-1:0] fwords [0:7];
   int            fifo_n;
   logic          fifo_clr;
   logic          force_stall;
   logic          stall_rand;
   logic          req_rand;
   logic          req_hold;
   logic          stall;
   logic [3:0]    rd_ptr;
   logic [DW-1:0] mem [0:MD-1];

   assign fifo_empty = stall || (int'(rd_ptr) >= fifo_n);
   assign fifo_dout  = fwords[rd_ptr[2:0]];

   always @(posedge clk) begin
      if (fifo_clr) rd_ptr <= '0;
      else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1'b1;
   end

   always @(posedge clk) begin
      if (glb_we_a) begin
         for (int l = 0; l < 4; l++) begin
            mem[int'(glb_addr_a) + l] <= glb_wdata_a[16*l +: 16];
         end
      end
      if (glb_re_b) glb_rdata_b <= mem[glb_addr_b];
   end

   always @(posedge clk) begin
      #2;
      stall    = force_stall || (stall_rand && ($urandom_range(0, 2) == 0));
      bias_req = req_rand ? ($urandom_range(0, 1) == 1) : req_hold;
   end

   // reference model and checking
   typedef struct {
      logic [AW-1:0] addr;
      logic [FW-1:0] data;
   } wr_t;
   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
   } bias_t;

   wr_t   exp_wr [$];
   bias_t exp_b  [$];
   int    acc_q  [$];
   int    n_vec;
   int    n_err;
   int    cyc;
   int    nw;
   int    busy_cyc;
   logic  ld_exp;
   logic  post_done;
   logic  bad_prev;
   logic  rst_prev;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic build_model(input int nb, input int np);
      logic [FW-1:0] w;
      exp_wr.delete();
      exp_b.delete();
      acc_q.delete();
      nw = (nb + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         w = fwords[k];
         if (PAD && (k == nw - 1) && (nb % 4 != 0)) begin
            for (int l = nb % 4; l < 4; l++) w[16*l +: 16] = '0;
         end
         exp_wr.push_back('{addr: AW'(4 * k), data: w});
      end
      for (int p = 0; p < np; p++) begin
         for (int i = 0; i < nb; i++) begin
            w = fwords[i / 4];
            exp_b.push_back('{idx: AW'(i), data: w[16*(i%4) +: 16]});
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; nw = 0; busy_cyc = 0;
      ld_exp = 0; post_done = 0; bad_prev = 0; rst_prev = 0;
   end

   always @(negedge clk) begin
      wr_t   ew;
      bias_t eb;
      int    a;
      cyc++;
      busy_cyc = busy ? busy_cyc + 1 : 0;
      if (busy_cyc > 2500) check("watchdog", 64'(busy_cyc), 0);
      if (rst_prev) begin
         check("rst_outs", 64'(|{fifo_rd_en, glb_we_a, glb_re_a,
               glb_addr_a, glb_wdata_a, glb_we_b, glb_re_b, glb_addr_b,
               bias_ready, bias_valid, bias_data, bias_idx, busy,
               load_done, done}), 0);
      end
      if (reset) begin
         exp_wr.delete();
         exp_b.delete();
         acc_q.delete();
         ld_exp = 0;
         post_done = 0;
         bad_prev = 0;
      end else begin
         if (post_done) begin
            check("busy_after_done", 64'(busy), 0);
            check("fifo_pops", 64'(rd_ptr), 64'(nw));
            post_done = 0;
         end
         if (bad_prev) begin
            check("bad_start", 64'(busy), 0);
            bad_prev = 0;
         end
         check("load_done", 64'(load_done), 64'(ld_exp));
         ld_exp = 0;
         check("ro_ports", 64'({glb_re_a, glb_we_b}), 0);
         check("pop_eq_we", 64'(fifo_rd_en), 64'(glb_we_a));
         if (!busy) check("ready_idle", 64'(bias_ready), 0);
         if (fifo_empty) check("stall_wr", 64'({fifo_rd_en, glb_we_a}), 0);
         if (glb_we_a) begin
            if (exp_wr.size() == 0) begin
               check("extra_wr", 64'(glb_we_a), 0);
            end else begin
               ew = exp_wr.pop_front();
               check("wr_addr", 64'(glb_addr_a), 64'(ew.addr));
               check("wr_data", glb_wdata_a, ew.data);
               if (exp_wr.size() == 0) ld_exp = 1;
            end
         end
         if (bias_req && bias_ready) acc_q.push_back(cyc);
         if (bias_valid) begin
            if (exp_b.size() == 0) begin
               check("spur_valid", 64'(bias_valid), 0);
            end else begin
               eb = exp_b.pop_front();
               check("bias_idx", 64'(bias_idx), 64'(eb.idx));
               check("bias_data", 64'(bias_data), 64'(eb.data));
               if (acc_q.size() == 0) begin
                  check("latency_q", 64'(acc_q.size()), 1);
               end else begin
                  a = acc_q.pop_front();
                  check("latency", 64'(cyc - a), 2);
               end
               check("done", 64'(done), 64'(exp_b.size() == 0));
               if (exp_b.size() == 0) post_done = 1;
            end
         end else begin
            check("done_no_valid", 64'(done), 0);
         end
         if (start && !busy) begin
            if ((cfg_num_bias >= 1) && (cfg_num_bias <= MD)
                && (cfg_num_passes != 0)) begin
               build_model(int'(cfg_num_bias), int'(cfg_num_passes));
            end else begin
               bad_prev = 1;
            end
         end
      end
      rst_prev = reset;
   end

   // stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int nb, input int np);
      for (int k = 0; k < 8; k++) fwords[k] = {$urandom, $urandom};
      fifo_n = (nb + 3) / 4 + 2;
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
      cfg_num_bias = (AW+1)'(nb);
      cfg_num_passes = PW'(np);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) break;
      end
      tick();
      tick();
      if (busy) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      cfg_num_bias = '0;
      cfg_num_passes = '0;
      fifo_n = 0;
      fifo_clr = 1'b1;
      force_stall = 1'b0;
      stall_rand = 1'b0;
      req_rand = 1'b0;
      req_hold = 1'b1;
      stall = 1'b0;
      bias_req = 1'b0;
      for (int k = 0; k < 8; k++) fwords[k] = '0;
      repeat (3) tick();
      reset = 1'b0;
      fifo_clr = 1'b0;
      tick();

      do_start(8, 1);
      wait_done();

      do_start(3, 2);
      repeat (4) tick();
      cfg_num_bias = (AW+1)'(16);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();

      do_start(16, 1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd_ptr == 4'd2) break;
      end
      tick();
      force_stall = 1'b1;
      repeat (3) tick();
      force_stall = 1'b0;
      wait_done();

      do_start(5, 1);
      wait_done();

      req_rand = 1'b1;
      do_start(1, 3);
      wait_done();
      req_rand = 1'b0;

      do_start(0, 1);
      repeat (3) tick();
      do_start(17, 1);
      repeat (3) tick();
      do_start(4, 0);
      repeat (3) tick();

      do_start(8, 1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bias_req && bias_ready) break;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) tick();
      do_start(8, 1);
      wait_done();

      for (int t = 0; t < 20; t++) begin
         req_rand = 1'($urandom_range(0, 1));
         stall_rand = 1'($urandom_range(0, 1));
         do_start(int'($urandom_range(1, 16)), int'($urandom_range(1, 3)));
         wait_done();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
